// File: rtl/prog_delay_pkg.sv
// prog_delay_pkg: shared helpers for the programmable delay line.
//   delay_w()     - width of delay/fill fields, clog2(max_depth+1)
//   addr_w()      - width of buffer pointers, clog2(max_depth), min 1
//   sample_w()    - packed sample width for a channel count / sample width
//   clamp_delay() - maps a requested delay into 1..max_depth
//   SAMPLE_W      - packed sample width of the default configuration
package prog_delay_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned SAMPLE_W       = DEF_DATA_WIDTH * DEF_NUM_CH;

  function automatic int unsigned delay_w(input int unsigned max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned max_depth);
    return (max_depth < 2) ? 1 : $clog2(max_depth);
  endfunction

  function automatic int unsigned sample_w(input int unsigned data_width,
                                           input int unsigned num_ch);
    return data_width * num_ch;
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_depth);
    if (req == 0) return 1;
    if (req > max_depth) return max_depth;
    return req;
  endfunction

endpackage

// File: rtl/prog_delay_ram.sv
// prog_delay_ram: simple dual-port sample buffer for prog_delay_line.
// Synchronous write port, combinational read port. Contents are not reset.
// Ports:
//   clk - write clock
//   we  - write enable
//   wa  - write address
//   wd  - write data
//   ra  - read address
//   rd  - read data (combinational)
module prog_delay_ram
  import prog_delay_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable multi-channel sample delay.
// Each accepted sample x[k] (nd high) produces q = x[k-D+1] one clock later,
// D loadable in 1..MAX_DEPTH. Storage is a circular buffer in prog_delay_ram.
// Optional build macro: PROG_DELAY_MASK_EN - forces q to 0 while q_valid is 0.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   nd        - din accepted this cycle
//   din       - packed samples, ch0 in LSBs
//   delay_ld  - load delay_in (clamped) this cycle
//   delay_in  - requested delay
//   delay_cur - active delay D
//   q         - delayed samples
//   q_stb     - one-cycle pulse, q updated (nd delayed by 1 clk)
//   q_valid   - q holds a fully-primed sample
module prog_delay_line
  import prog_delay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned MAX_DEPTH     = 64,
  parameter int unsigned DEFAULT_DELAY = 8,
  localparam int unsigned SW = sample_w(DATA_WIDTH, NUM_CH),
  localparam int unsigned DW = delay_w(MAX_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nd,
  input  logic [SW-1:0] din,
  input  logic          delay_ld,
  input  logic [DW-1:0] delay_in,
  output logic [DW-1:0] delay_cur,
  output logic [SW-1:0] q,
  output logic          q_stb,
  output logic          q_valid
);

  localparam int unsigned AW = addr_w(MAX_DEPTH);
  localparam logic [DW-1:0] RST_DELAY = DW'(clamp_delay(DEFAULT_DELAY, MAX_DEPTH));
  localparam logic [DW-1:0] DEPTH_D   = DW'(MAX_DEPTH);
  localparam logic [DW:0]   DEPTH_X   = (DW+1)'(MAX_DEPTH);
  localparam logic [AW-1:0] LAST_WP   = AW'(MAX_DEPTH - 1);

  logic [AW-1:0] wp, wp_next, rd_addr;
  logic [DW-1:0] fill, fill_base, fill_inc;
  logic [DW-1:0] d_clamped, d_eff;
  logic [DW:0]   wp_x, off_x, rd_x;
  logic [SW-1:0] rd_data, q_reg;

  prog_delay_ram #(
    .WIDTH (SW),
    .DEPTH (MAX_DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (nd),
    .wa  (wp),
    .wd  (din),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  // A load in the same cycle as nd applies to that sample and restarts fill.
  always_comb begin
    d_clamped = DW'(clamp_delay(32'(delay_in), MAX_DEPTH));
    d_eff     = delay_ld ? d_clamped : delay_cur;
    fill_base = delay_ld ? '0 : fill;
    fill_inc  = (fill_base >= DEPTH_D) ? fill_base : fill_base + 1'b1;
    wp_next   = (wp == LAST_WP) ? '0 : wp + 1'b1;
  end

  // Read slot = wp - (D-1) mod MAX_DEPTH without a power-of-two assumption.
  // For D>1 this never equals wp, so the combinational read sees old data.
  always_comb begin
    wp_x    = (DW+1)'(wp);
    off_x   = {1'b0, d_eff} - 1'b1;
    rd_x    = (wp_x >= off_x) ? (wp_x - off_x) : (wp_x + DEPTH_X - off_x);
    rd_addr = AW'(rd_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      fill      <= '0;
      delay_cur <= RST_DELAY;
      q_reg     <= '0;
      q_stb     <= 1'b0;
      q_valid   <= 1'b0;
    end else begin
      q_stb <= nd;
      if (delay_ld) delay_cur <= d_clamped;
      if (nd) begin
        wp      <= wp_next;
        fill    <= fill_inc;
        q_reg   <= (d_eff == DW'(1)) ? din : rd_data;
        q_valid <= (fill_inc >= d_eff);
      end else if (delay_ld) begin
        fill    <= '0;
        q_valid <= 1'b0;
      end
    end
  end

`ifdef PROG_DELAY_MASK_EN
  assign q = q_valid ? q_reg : '0;
`else
  assign q = q_reg;
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: directed self-checking bench for prog_delay_line
// (DATA_WIDTH=16, NUM_CH=2, MAX_DEPTH=64, DEFAULT_DELAY=8).
// Builds with or without PROG_DELAY_MASK_EN; expectations for unprimed q follow the macro.
module tb_prog_delay_line;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nd;
  logic [31:0] din;
  logic        delay_ld;
  logic [6:0]  delay_in;
  logic [6:0]  delay_cur;
  logic [31:0] q;
  logic        q_stb;
  logic        q_valid;

  int errors = 0;
  int checks = 0;

  prog_delay_line dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nd        (nd),
    .din       (din),
    .delay_ld  (delay_ld),
    .delay_in  (delay_in),
    .delay_cur (delay_cur),
    .q         (q),
    .q_stb     (q_stb),
    .q_valid   (q_valid)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Expected q for an unprimed output whose raw buffer value is known.
  function automatic logic [31:0] unprimed(input logic [31:0] raw);
`ifdef PROG_DELAY_MASK_EN
    return 32'h0;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one clock cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic nd_v, input logic [31:0] d,
                     input logic ld_v, input logic [6:0] dv);
    nd       = nd_v;
    din      = d;
    delay_ld = ld_v;
    delay_in = dv;
    @(posedge clk);
    #1;
    nd       = 1'b0;
    delay_ld = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    nd       = 1'b0;
    din      = '0;
    delay_ld = 1'b0;
    delay_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_stb", 32'(q_stb), 32'h0);
    chk("rst_valid", 32'(q_valid), 32'h0);
    chk("rst_delay", 32'(delay_cur), 32'd8);
    rst_n = 1'b1;

    // Default delay 8, nd every cycle, din = k.
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 32'(k), 1'b0, 7'd0);
      chk("d8_stb", 32'(q_stb), 32'h1);
      chk("d8_valid", 32'(q_valid), 32'(k >= 7));
      if (k >= 7) chk("d8_q", q, 32'(k - 7));
`ifdef PROG_DELAY_MASK_EN
      else chk("d8_q_mask", q, 32'h0);
`endif
    end
    cyc(1'b0, 32'h0, 1'b0, 7'd0);
    chk("idle_stb", 32'(q_stb), 32'h0);
    chk("idle_q", q, 32'd12);

    // Load D=3 then gapped nd (1 of 3 cycles).
    cyc(1'b0, 32'h0, 1'b1, 7'd3);
    chk("ld3_delay", 32'(delay_cur), 32'd3);
    chk("ld3_valid", 32'(q_valid), 32'h0);
    chk("ld3_q_hold", q, unprimed(32'd12));
    for (int j = 0; j < 9; j++) begin
      cyc(1'b1, 32'(100 + j), 1'b0, 7'd0);
      chk("gap_stb", 32'(q_stb), 32'h1);
      chk("gap_valid", 32'(q_valid), 32'(j >= 2));
      if (j >= 2) chk("gap_q", q, 32'(100 + j - 2));
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 7'd0);
        chk("gap_idle_stb", 32'(q_stb), 32'h0);
        chk("gap_idle_valid", 32'(q_valid), 32'(j >= 2));
        if (j >= 2) chk("gap_idle_q", q, 32'(100 + j - 2));
      end
    end

    // Clamp: 0 -> 1, 69 -> 64; D=1 bypass with simultaneous load.
    cyc(1'b0, 32'h0, 1'b1, 7'd0);
    chk("clamp_lo", 32'(delay_cur), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 7'd69);
    chk("clamp_hi", 32'(delay_cur), 32'd64);
    cyc(1'b1, 32'h0000_0055, 1'b1, 7'd1);
    chk("byp_delay", 32'(delay_cur), 32'd1);
    chk("byp_valid", 32'(q_valid), 32'h1);
    chk("byp_q", q, 32'h0000_0055);
    cyc(1'b1, 32'h0000_0066, 1'b0, 7'd0);
    chk("byp_q2", q, 32'h0000_0066);

    // D=64 across more than three pointer wraps.
    cyc(1'b0, 32'h0, 1'b1, 7'd69);
    for (int k = 0; k < 200; k++) begin
      cyc(1'b1, 32'(1000 + k), 1'b0, 7'd0);
      chk("d64_valid", 32'(q_valid), 32'(k >= 63));
      if (k >= 63) chk("d64_q", q, 32'(1000 + k - 63));
    end

    // Load with nd in the same cycle, 8 -> 2.
    cyc(1'b0, 32'h0, 1'b1, 7'd8);
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'(200 + k), 1'b0, 7'd0);
    chk("pre_ldnd_q", q, 32'd202);
    cyc(1'b1, 32'd300, 1'b1, 7'd2);
    chk("ldnd_delay", 32'(delay_cur), 32'd2);
    chk("ldnd_valid", 32'(q_valid), 32'h0);
    chk("ldnd_q", q, unprimed(32'd209));
    cyc(1'b1, 32'd301, 1'b0, 7'd0);
    chk("ldnd_valid2", 32'(q_valid), 32'h1);
    chk("ldnd_q2", q, 32'd300);

    // Mid-stream reset at D=4.
    cyc(1'b0, 32'h0, 1'b1, 7'd4);
    for (int k = 0; k < 6; k++) cyc(1'b1, 32'(400 + k), 1'b0, 7'd0);
    chk("d4_q", q, 32'd402);
    chk("d4_valid", 32'(q_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_q", q, 32'h0);
    chk("mrst_valid", 32'(q_valid), 32'h0);
    chk("mrst_stb", 32'(q_stb), 32'h0);
    chk("mrst_delay", 32'(delay_cur), 32'd8);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 7'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'(500 + k), 1'b0, 7'd0);
      chk("reprime_valid", 32'(q_valid), 32'(k == 3));
    end
    chk("reprime_q", q, 32'd500);

    // Stale buffer contents: fill every slot with A5A5, then restart priming.
    for (int k = 0; k < 64; k++) cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 7'd0);
    cyc(1'b0, 32'h0, 1'b1, 7'd4);
    chk("stale_ld_q", q, unprimed(32'hA5A5_A5A5));
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 32'(k), 1'b0, 7'd0);
      chk("stale_valid", 32'(q_valid), 32'(k == 4));
      if (k < 4) chk("stale_q", q, unprimed(32'hA5A5_A5A5));
      else       chk("stale_q_primed", q, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
